squeeze_ctrl: RTL and testbench

Sequencer for the Keccak squeeze phase. It drives the byte offset into the combinational `squeeze_unit` and registers each window into an AXI-Stream output beat with backpressure. When the rate is exhausted it requests a Keccak-f permutation. For fixed-length modes it ends the stream on the `squeeze_unit` last flag; for SHAKE modes it ends on a programmed output length.

---
 rtl/squeeze_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_squeeze_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/squeeze_ctrl.sv
// Purpose : Keccak squeeze-phase sequencer; walks the byte offset through the squeeze_unit
//           window, registers each window as an AXI-Stream beat, requests permutations.
// Latency : first beat valid one cycle after start is sampled; then one beat per cycle.
// Backpr. : a held beat stays stable until tready; no new window is captured while stalled.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   start_i, keccak_mode_i,    start pulse and per-run configuration (sampled on accepted start)
//   rate_i, out_len_i
//   su_*                       squeeze_unit handshake: offset out, window data/keep/last/perm in
//   perm_start_o, perm_done_i  permutation request / completion pulses
//   m_axis_*                   AXI-Stream master output
//   busy_o, done_o             run status
// Mode encoding: only the two SHAKE codes (parameters below) select XOF behaviour; every
// other code is treated as a fixed-length digest ending on su_last_i.
module squeeze_ctrl #(
   parameter int DWIDTH         = 256,
   parameter int LEN_WIDTH      = 16,
   parameter int MODE_SEL_WIDTH = 3,
   parameter int RATE_WIDTH     = 11,
   parameter logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 = 'd4,
   parameter logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 = 'd5
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
   input  logic [RATE_WIDTH-1:0]     rate_i,
   input  logic [LEN_WIDTH-1:0]      out_len_i,
   output logic [RATE_WIDTH-1:0]     su_bytes_squeezed_o,
   input  logic [DWIDTH-1:0]         su_data_i,
   input  logic [DWIDTH/8-1:0]       su_keep_i,
   input  logic                      su_last_i,
   input  logic                      su_perm_needed_i,
   output logic                      perm_start_o,
   input  logic                      perm_done_i,
   output logic [DWIDTH-1:0]         m_axis_tdata_o,
   output logic [DWIDTH/8-1:0]       m_axis_tkeep_o,
   output logic                      m_axis_tlast_o,
   output logic                      m_axis_tvalid_o,
   input  logic                      m_axis_tready_i,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int BW = DWIDTH / 8;
   // One bit wider than either operand so byte-count arithmetic never overflows.
   localparam int CW = ((LEN_WIDTH > RATE_WIDTH) ? LEN_WIDTH : RATE_WIDTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SQUEEZE, S_PERM_REQ, S_PERM_WAIT, S_DRAIN, S_FINISH
   } state_t;

   state_t                state_q, state_d;
   logic                  shake_q, shake_d;
   logic [RATE_WIDTH-1:0] rate_bytes_q, rate_bytes_d;
   logic [LEN_WIDTH-1:0]  len_rem_q, len_rem_d;
   logic [RATE_WIDTH-1:0] bsq_q, bsq_d;
   logic [DWIDTH-1:0]     tdata_q, tdata_d;
   logic [BW-1:0]         tkeep_q, tkeep_d;
   logic                  tlast_q, tlast_d;
   logic                  tvalid_q, tvalid_d;

   logic [CW-1:0] rate_rem, len_ext, keep_cnt, beat_bytes;
   logic [BW-1:0] beat_keep;
   logic          beat_last;
   logic          hs, can_cap;

   // Beat sizing for the window at the current offset.
   always_comb begin
      rate_rem  = CW'(rate_bytes_q) - CW'(bsq_q);
      len_ext   = CW'(len_rem_q);
      keep_cnt  = '0;
      for (int i = 0; i < BW; i++) begin
         keep_cnt = keep_cnt + CW'(su_keep_i[i]);
      end
      if (shake_q) begin
         beat_bytes = CW'(BW);
         if (rate_rem < beat_bytes) beat_bytes = rate_rem;
         if (len_ext < beat_bytes)  beat_bytes = len_ext;
      end else begin
         beat_bytes = keep_cnt;
      end
      beat_keep = '0;
      for (int i = 0; i < BW; i++) begin
         beat_keep[i] = (CW'(i) < beat_bytes);
      end
      beat_last = shake_q ? (len_ext == beat_bytes) : su_last_i;
   end

   always_comb begin
      state_d      = state_q;
      shake_d      = shake_q;
      rate_bytes_d = rate_bytes_q;
      len_rem_d    = len_rem_q;
      bsq_d        = bsq_q;
      tdata_d      = tdata_q;
      tkeep_d      = tkeep_q;
      tlast_d      = tlast_q;
      tvalid_d     = tvalid_q;

      hs      = tvalid_q && m_axis_tready_i;
      can_cap = !tvalid_q || m_axis_tready_i;
      // A held beat drains in any state, including while a permutation is in progress.
      if (hs) tvalid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               shake_d      = (keccak_mode_i == MODE_SHAKE128) || (keccak_mode_i == MODE_SHAKE256);
               rate_bytes_d = RATE_WIDTH'(rate_i >> 3);
               len_rem_d    = out_len_i;
               bsq_d        = '0;
               state_d      = S_SQUEEZE;
            end
         end
         S_SQUEEZE: begin
            // A zero-length XOF is the only way to arrive here with nothing left:
            // a real last beat always diverts to DRAIN. No beat is produced.
            if (shake_q && (len_rem_q == '0)) begin
               state_d = S_FINISH;
            end else if (can_cap) begin
               tdata_d  = su_data_i;
               tkeep_d  = shake_q ? beat_keep : su_keep_i;
               tlast_d  = beat_last;
               tvalid_d = 1'b1;
               bsq_d    = bsq_q + RATE_WIDTH'(beat_bytes);
               if (shake_q) len_rem_d = len_rem_q - LEN_WIDTH'(beat_bytes);
               // Last wins over an exhausted rate: no permutation after the final beat.
               if (beat_last)             state_d = S_DRAIN;
               else if (su_perm_needed_i) state_d = S_PERM_REQ;
            end
         end
         S_PERM_REQ:  state_d = S_PERM_WAIT;
         S_PERM_WAIT: begin
            if (perm_done_i) begin
               bsq_d   = '0;
               state_d = S_SQUEEZE;
            end
         end
         S_DRAIN:  if (hs) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         shake_q      <= 1'b0;
         rate_bytes_q <= '0;
         len_rem_q    <= '0;
         bsq_q        <= '0;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tlast_q      <= 1'b0;
         tvalid_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         shake_q      <= shake_d;
         rate_bytes_q <= rate_bytes_d;
         len_rem_q    <= len_rem_d;
         bsq_q        <= bsq_d;
         tdata_q      <= tdata_d;
         tkeep_q      <= tkeep_d;
         tlast_q      <= tlast_d;
         tvalid_q     <= tvalid_d;
      end
   end

   // Status outputs decode straight from state so reset clears them immediately.
   assign su_bytes_squeezed_o = bsq_q;
   assign perm_start_o        = (state_q == S_PERM_REQ);
   assign done_o              = (state_q == S_FINISH);
   assign busy_o              = (state_q != S_IDLE);
   assign m_axis_tdata_o      = tdata_q;
   assign m_axis_tkeep_o      = tkeep_q;
   assign m_axis_tlast_o      = tlast_q;
   assign m_axis_tvalid_o     = tvalid_q;

endmodule

// File: tb/tb_squeeze_ctrl.sv
// Purpose : self-checking bench for squeeze_ctrl with a behavioural squeeze_unit,
//           a permutation responder, a patterned tready driver and a beat scoreboard.
// Latency : n/a (bench).
// Backpr. : tready follows a per-test 4-cycle pattern.
module tb_squeeze_ctrl;

   logic         clk, rst_n, start;
   logic [2:0]   mode;
   logic [10:0]  rate;
   logic [15:0]  out_len;
   logic [10:0]  bsq;
   logic [255:0] su_data;
   logic [31:0]  su_keep;
   logic         su_last, su_perm, perm_start, perm_done;
   logic [255:0] tdata;
   logic [31:0]  tkeep;
   logic         tlast, tvalid, tready, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [255:0] d;
      logic [31:0]  k;
      logic         l;
   } beat_t;
   beat_t exp_q[$];
   int    exp_perms;

   bit   cur_shake;
   int   cur_rate_b, cur_dlen, blk;
   logic [3:0] rdy_pat;
   int   rdy_i;

   int   cyc, busy_cnt, vld_cnt, perm_cnt, done_cnt, last_hs_cyc, done_cyc;

   squeeze_ctrl dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .start_i             (start),
      .keccak_mode_i       (mode),
      .rate_i              (rate),
      .out_len_i           (out_len),
      .su_bytes_squeezed_o (bsq),
      .su_data_i           (su_data),
      .su_keep_i           (su_keep),
      .su_last_i           (su_last),
      .su_perm_needed_i    (su_perm),
      .perm_start_o        (perm_start),
      .perm_done_i         (perm_done),
      .m_axis_tdata_o      (tdata),
      .m_axis_tkeep_o      (tkeep),
      .m_axis_tlast_o      (tlast),
      .m_axis_tvalid_o     (tvalid),
      .m_axis_tready_i     (tready),
      .busy_o              (busy),
      .done_o              (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // State-array byte at offset o of block b (block advances on each permutation).
   function automatic logic [7:0] dbyte(input int b, input int o);
      int v;
      v = b * 73 + o * 11 + 5;
      return v[7:0];
   endfunction

   function automatic logic [255:0] kmask(input logic [31:0] k);
      logic [255:0] m;
      for (int j = 0; j < 32; j++) m[j*8 +: 8] = {8{k[j]}};
      return m;
   endfunction

   // Behavioural squeeze_unit: window of up to 32 bytes at the DUT's offset.
   int su_n, su_rr;
   always_comb begin
      su_rr   = cur_rate_b - int'(bsq);
      su_n    = (su_rr < 32) ? su_rr : 32;
      su_perm = (int'(bsq) + su_n >= cur_rate_b);
      if (!cur_shake && (cur_dlen - int'(bsq) < su_n)) su_n = cur_dlen - int'(bsq);
      su_last = !cur_shake && (int'(bsq) + su_n >= cur_dlen);
      su_data = '0;
      su_keep = '0;
      for (int j = 0; j < 32; j++) begin
         su_data[j*8 +: 8] = dbyte(blk, int'(bsq) + j);
         su_keep[j]        = (j < su_n);
      end
   end

   // Expected beat sequence for a run of len bytes at rate_b bytes per block.
   task automatic push_stream(input int rate_b, input int len);
      int off, b, rem, n;
      bit last;
      beat_t e;
      off = 0; b = 0; rem = len; last = 1'b0; exp_perms = 0;
      while (!last && rem > 0) begin
         n = 32;
         if (rate_b - off < n) n = rate_b - off;
         if (rem < n) n = rem;
         e.d = '0;
         e.k = '0;
         for (int j = 0; j < n; j++) begin
            e.d[j*8 +: 8] = dbyte(b, off + j);
            e.k[j]        = 1'b1;
         end
         last = (rem == n);
         e.l  = last;
         exp_q.push_back(e);
         off += n;
         rem -= n;
         if (!last && off == rate_b) begin
            b++;
            off = 0;
            exp_perms++;
         end
      end
   endtask

   // Permutation core: answers each request three cycles later.
   initial begin
      perm_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && perm_start) begin
            repeat (3) @(posedge clk);
            #1 perm_done = 1'b1;
            blk++;
            @(posedge clk);
            #1 perm_done = 1'b0;
         end
      end
   end

   initial begin
      tready = 1'b0;
      forever begin
         @(posedge clk);
         #1 tready = rdy_pat[rdy_i];
         rdy_i = (rdy_i + 1) % 4;
      end
   end

   // Monitor: scoreboard pops on handshake, AXI stability while stalled, event counters.
   initial begin
      logic         prev_stall, prev_l;
      logic [255:0] prev_d;
      logic [31:0]  prev_k;
      beat_t        e;
      prev_stall = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_vld", tvalid, 1);
               chk("hold_dat", tdata, prev_d);
               chk("hold_keep", tkeep, prev_k);
               chk("hold_last", tlast, prev_l);
            end
            if (busy)       busy_cnt++;
            if (tvalid)     vld_cnt++;
            if (perm_start) perm_cnt++;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (tvalid && tready) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", tvalid, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("tkeep", tkeep, e.k);
                  chk("tdata", tdata & kmask(e.k), e.d);
                  chk("tlast", tlast, e.l);
               end
               if (tlast) last_hs_cyc = cyc;
            end
            prev_stall = tvalid && !tready;
            prev_d     = tdata;
            prev_k     = tkeep;
            prev_l     = tlast;
         end
      end
   end

   task automatic run_test(input string tag, input bit shk, input logic [2:0] md,
                           input int rate_bits, input int len, input logic [3:0] pat,
                           input bit poke);
      bit found;
      cur_shake  = shk;
      cur_rate_b = rate_bits / 8;
      cur_dlen   = len;
      blk        = 0;
      push_stream(rate_bits / 8, len);
      @(posedge clk);
      #1;
      rdy_pat = pat; rdy_i = 0;
      busy_cnt = 0; vld_cnt = 0; perm_cnt = 0; done_cnt = 0;
      last_hs_cyc = -1; done_cyc = -1;
      start = 1'b1; mode = md; rate = 11'(rate_bits); out_len = 16'(len);
      @(posedge clk);
      // Scramble the configuration inputs: the DUT must have sampled them already.
      #1 start = 1'b0; mode = 3'd7; rate = '0; out_len = 16'd5;
      @(negedge clk);
      chk({tag, "_busy_rise"}, busy, 1);
      chk({tag, "_vld_k"}, tvalid, 0);
      @(negedge clk);
      chk({tag, "_vld_k1"}, tvalid, (len > 0));
      found = done;
      if (poke) begin
         // A start while busy must be ignored.
         @(posedge clk);
         #1 start = 1'b1; mode = 3'd1; rate = 11'd1088; out_len = 16'd3;
         @(posedge clk);
         #1 start = 1'b0;
      end
      for (int t = 0; t < 400 && !found; t++) begin
         @(negedge clk);
         if (done) found = 1'b1;
      end
      chk({tag, "_done_seen"}, found, 1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_fall"}, busy, 0);
      repeat (3) @(negedge clk);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_perms"}, perm_cnt, exp_perms);
      chk({tag, "_beats_left"}, exp_q.size(), 0);
      if (len > 0) begin
         chk({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
      end else begin
         chk({tag, "_busy_cyc"}, busy_cnt, 2);
         chk({tag, "_no_vld"}, vld_cnt, 0);
      end
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; start = 1'b0; mode = '0; rate = '0; out_len = '0;
      cur_shake = 1'b0; cur_rate_b = 136; cur_dlen = 32; blk = 0;
      rdy_pat = 4'hF; rdy_i = 0;
      busy_cnt = 0; vld_cnt = 0; perm_cnt = 0; done_cnt = 0;
      last_hs_cyc = -1; done_cyc = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_perm", perm_start, 0);
      chk("rst_bsq", bsq, 0);
      chk("rst_tkeep", tkeep, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tdata", tdata, 0);
      rst_n = 1'b1;

      run_test("sha3_256", 1'b0, 3'd1, 1088, 32, 4'hF, 1'b0);
      run_test("sha3_512", 1'b0, 3'd3, 576, 64, 4'b1001, 1'b0);
      run_test("shake128_200", 1'b1, 3'd4, 1344, 200, 4'hF, 1'b1);
      run_test("shake256_0", 1'b1, 3'd5, 1088, 0, 4'hF, 1'b0);

      // Reset while a beat is held valid.
      cur_shake = 1'b1; cur_rate_b = 168; cur_dlen = 200; blk = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rdy_pat = 4'h0; rdy_i = 0;
      start = 1'b1; mode = 3'd4; rate = 11'd1344; out_len = 16'd200;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge clk);
         if (tvalid) found = 1'b1;
      end
      chk("mid_pre_vld", found, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_tvalid", tvalid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_perm", perm_start, 0);
      chk("mid_done", done, 0);
      chk("mid_tkeep", tkeep, 0);
      chk("mid_tdata", tdata, 0);
      chk("mid_bsq", bsq, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rdy_pat = 4'hF;

      run_test("shake128_40", 1'b1, 3'd4, 1344, 40, 4'hF, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
